// File: rtl/stage_if_if.sv
// Wishbone classic instruction-fetch bus between the IF stage (master) and memory (slave).
// Signal names keep the master-side direction suffixes so both ends read the same.
interface stage_if_if;
    logic [31:0] iwbm_addr_o;
    logic        iwbm_cyc_o;
    logic        iwbm_stb_o;
    logic [31:0] iwbm_dat_i;
    logic        iwbm_ack_i;
    logic        iwbm_err_i;

    modport master (
        output iwbm_addr_o, iwbm_cyc_o, iwbm_stb_o,
        input  iwbm_dat_i, iwbm_ack_i, iwbm_err_i
    );

    modport slave (
        input  iwbm_addr_o, iwbm_cyc_o, iwbm_stb_o,
        output iwbm_dat_i, iwbm_ack_i, iwbm_err_i
    );
endinterface

// File: rtl/stage_if.sv
// Instruction Fetch stage: PC, Wishbone classic fetch, one-entry stall buffer and IF/ID register.
// state  | meaning
// FETCH  | normal fetching; cycles start when not stalled, back-to-back on ack
// HOLD   | an acked entry sits in the buffer waiting for decode to unstall
// KILL   | redirected while a cycle was in flight; wait for ack/err and drop the data
// HALT   | exception entry parked in IF/ID; no fetching until a redirect
module stage_if #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    stage_if_if.master        iwbm,
    output logic [31:0]       instruction_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    output logic              e_inst_addr_misaligned_o,
    output logic              e_inst_access_fault_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_addr, w_addr_n;
    logic        r_cyc, w_cyc_n;
    logic [31:0] r_buf_inst, w_buf_inst_n;
    logic [31:0] r_buf_pc, w_buf_pc_n;
    logic        r_buf_fault, w_buf_fault_n;
    logic [31:0] r_inst, w_inst_n;
    logic [31:0] r_pc_o, w_pc_o_n;
    logic        r_valid, w_valid_n;
    logic        r_e_mis, w_e_mis_n;
    logic        r_e_fault, w_e_fault_n;

    logic        w_done;
    logic [31:0] w_pc_inc;
    logic [31:0] w_entry_inst;

    assign w_done       = r_cyc & (iwbm.iwbm_ack_i | iwbm.iwbm_err_i);
    assign w_pc_inc     = r_pc + 32'd4;
    assign w_entry_inst = iwbm.iwbm_err_i ? NOP_INST : iwbm.iwbm_dat_i;

    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_cyc_n       = r_cyc;
        w_buf_inst_n  = r_buf_inst;
        w_buf_pc_n    = r_buf_pc;
        w_buf_fault_n = r_buf_fault;
        w_inst_n      = r_inst;
        w_pc_o_n      = r_pc_o;
        w_valid_n     = r_valid;
        w_e_mis_n     = r_e_mis;
        w_e_fault_n   = r_e_fault;

        if (redirect_i) begin
            w_pc_n      = redirect_pc_i;
            w_valid_n   = 1'b0;
            w_e_mis_n   = 1'b0;
            w_e_fault_n = 1'b0;
            w_inst_n    = NOP_INST;
            if (redirect_pc_i[1:0] != 2'b00) begin
                // an in-flight cycle still has to be closed out, so HALT keeps cyc until ack/err
                w_valid_n = 1'b1;
                w_e_mis_n = 1'b1;
                w_pc_o_n  = redirect_pc_i;
                w_state_n = S_HALT;
                w_cyc_n   = r_cyc & ~w_done;
            end else if (r_cyc && !w_done) begin
                w_state_n = S_KILL;
            end else begin
                w_state_n = S_FETCH;
                w_cyc_n   = ~stall_i;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_done) begin
                        if (!iwbm.iwbm_err_i)
                            w_pc_n = w_pc_inc;
                        if (stall_i) begin
                            w_buf_inst_n  = w_entry_inst;
                            w_buf_pc_n    = r_pc;
                            w_buf_fault_n = iwbm.iwbm_err_i;
                            w_cyc_n       = 1'b0;
                            w_state_n     = S_HOLD;
                        end else begin
                            w_inst_n    = w_entry_inst;
                            w_pc_o_n    = r_pc;
                            w_valid_n   = 1'b1;
                            w_e_mis_n   = 1'b0;
                            w_e_fault_n = iwbm.iwbm_err_i;
                            if (iwbm.iwbm_err_i) begin
                                w_cyc_n   = 1'b0;
                                w_state_n = S_HALT;
                            end
                        end
                    end else if (!stall_i) begin
                        w_valid_n   = 1'b0;
                        w_inst_n    = NOP_INST;
                        w_e_mis_n   = 1'b0;
                        w_e_fault_n = 1'b0;
                        w_cyc_n     = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        w_inst_n    = r_buf_inst;
                        w_pc_o_n    = r_buf_pc;
                        w_valid_n   = 1'b1;
                        w_e_mis_n   = 1'b0;
                        w_e_fault_n = r_buf_fault;
                        w_cyc_n     = ~r_buf_fault;
                        w_state_n   = r_buf_fault ? S_HALT : S_FETCH;
                    end
                end
                S_KILL: begin
                    if (w_done) begin
                        w_cyc_n   = ~stall_i;
                        w_state_n = S_FETCH;
                    end
                end
                S_HALT: begin
                    if (w_done)
                        w_cyc_n = 1'b0;
                end
                default: begin
                    w_state_n = S_FETCH;
                    w_cyc_n   = 1'b0;
                end
            endcase
        end

        // address only moves when no cycle is carried over unacknowledged
        if (r_cyc && !w_done)
            w_addr_n = r_addr;
        else
            w_addr_n = {w_pc_n[31:2], 2'b00};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_ADDR;
            r_addr      <= RESET_ADDR;
            r_cyc       <= 1'b0;
            r_buf_inst  <= NOP_INST;
            r_buf_pc    <= 32'd0;
            r_buf_fault <= 1'b0;
            r_inst      <= NOP_INST;
            r_pc_o      <= 32'd0;
            r_valid     <= 1'b0;
            r_e_mis     <= 1'b0;
            r_e_fault   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_addr      <= w_addr_n;
            r_cyc       <= w_cyc_n;
            r_buf_inst  <= w_buf_inst_n;
            r_buf_pc    <= w_buf_pc_n;
            r_buf_fault <= w_buf_fault_n;
            r_inst      <= w_inst_n;
            r_pc_o      <= w_pc_o_n;
            r_valid     <= w_valid_n;
            r_e_mis     <= w_e_mis_n;
            r_e_fault   <= w_e_fault_n;
        end
    end

    assign iwbm.iwbm_addr_o        = r_addr;
    assign iwbm.iwbm_cyc_o         = r_cyc;
    assign iwbm.iwbm_stb_o         = r_cyc;
    assign instruction_o           = r_inst;
    assign pc_o                    = r_pc_o;
    assign valid_o                 = r_valid;
    assign e_inst_addr_misaligned_o = r_e_mis;
    assign e_inst_access_fault_o   = r_e_fault;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: back-to-back fetch, stall buffer, redirect kill, exceptions, pc wrap, async reset.
// Wishbone slave responses are driven cycle by cycle from the stimulus sequence below.
module tb_stage_if;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        e_inst_addr_misaligned_o;
    logic        e_inst_access_fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    stage_if_if bus ();

    stage_if dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .stall_i                  (stall_i),
        .redirect_i               (redirect_i),
        .redirect_pc_i            (redirect_pc_i),
        .iwbm                     (bus),
        .instruction_o            (instruction_o),
        .pc_o                     (pc_o),
        .valid_o                  (valid_o),
        .e_inst_addr_misaligned_o (e_inst_addr_misaligned_o),
        .e_inst_access_fault_o    (e_inst_access_fault_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i             = 1'b0;
        stall_i           = 1'b0;
        redirect_i        = 1'b0;
        redirect_pc_i     = 32'd0;
        bus.iwbm_dat_i    = 32'd0;
        bus.iwbm_ack_i    = 1'b0;
        bus.iwbm_err_i    = 1'b0;

        repeat (2) step();
        chk("rst_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd0);
        chk("rst_addr",  bus.iwbm_addr_o, 32'h8000_0000);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_inst",  instruction_o, 32'h0000_0013);
        chk("rst_pc_o",  pc_o, 32'd0);
        chk("rst_exc",   {30'd0, e_inst_addr_misaligned_o, e_inst_access_fault_o}, 32'd0);

        rst_i = 1'b1;
        step();
        chk("start_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("start_addr",  bus.iwbm_addr_o, 32'h8000_0000);
        chk("start_valid", {31'd0, valid_o}, 32'd0);

        // ack first fetch
        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'h0050_0093;
        step();
        chk("b2b_valid", {31'd0, valid_o}, 32'd1);
        chk("b2b_pc_o",  pc_o, 32'h8000_0000);
        chk("b2b_inst",  instruction_o, 32'h0050_0093);
        chk("b2b_addr",  bus.iwbm_addr_o, 32'h8000_0004);
        chk("b2b_stb",   {30'd0, bus.iwbm_cyc_o, bus.iwbm_stb_o}, 32'd3);

        // ack for 0x80000004 arrives while decode stalls
        stall_i = 1'b1;
        step();
        chk("stall_cyc",  {31'd0, bus.iwbm_cyc_o}, 32'd0);
        chk("stall_pc_o", pc_o, 32'h8000_0000);
        chk("stall_addr", bus.iwbm_addr_o, 32'h8000_0008);

        bus.iwbm_ack_i = 1'b0;
        step();
        chk("hold_cyc",  {31'd0, bus.iwbm_cyc_o}, 32'd0);
        chk("hold_pc_o", pc_o, 32'h8000_0000);

        stall_i = 1'b0;
        step();
        chk("unst_pc_o",  pc_o, 32'h8000_0004);
        chk("unst_valid", {31'd0, valid_o}, 32'd1);
        chk("unst_inst",  instruction_o, 32'h0050_0093);
        chk("unst_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("unst_addr",  bus.iwbm_addr_o, 32'h8000_0008);

        // redirect while 0x80000008 is pending, ack 3 cycles later
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        step();
        chk("kill_valid", {31'd0, valid_o}, 32'd0);
        chk("kill_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("kill_addr",  bus.iwbm_addr_o, 32'h8000_0008);
        redirect_i = 1'b0;
        repeat (2) step();
        chk("kill2_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("kill2_valid", {31'd0, valid_o}, 32'd0);
        chk("kill2_addr",  bus.iwbm_addr_o, 32'h8000_0008);

        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'hDEAD_BEEF;
        step();
        chk("kdone_valid", {31'd0, valid_o}, 32'd0);
        chk("kdone_inst",  instruction_o, 32'h0000_0013);
        chk("kdone_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("kdone_addr",  bus.iwbm_addr_o, 32'h8000_0100);

        // stall with no ack must not drop the cycle
        bus.iwbm_ack_i = 1'b0;
        stall_i        = 1'b1;
        step();
        chk("stl_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("stl_addr",  bus.iwbm_addr_o, 32'h8000_0100);
        chk("stl_valid", {31'd0, valid_o}, 32'd0);

        stall_i        = 1'b0;
        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'h0010_0113;
        step();
        chk("tgt_valid", {31'd0, valid_o}, 32'd1);
        chk("tgt_pc_o",  pc_o, 32'h8000_0100);
        chk("tgt_inst",  instruction_o, 32'h0010_0113);
        chk("tgt_addr",  bus.iwbm_addr_o, 32'h8000_0104);

        // misaligned redirect arriving with an ack: data dropped, no new cycle
        bus.iwbm_dat_i = 32'h1111_1111;
        redirect_i     = 1'b1;
        redirect_pc_i  = 32'h8000_0102;
        step();
        chk("mis_valid", {31'd0, valid_o}, 32'd1);
        chk("mis_flag",  {31'd0, e_inst_addr_misaligned_o}, 32'd1);
        chk("mis_fault", {31'd0, e_inst_access_fault_o}, 32'd0);
        chk("mis_pc_o",  pc_o, 32'h8000_0102);
        chk("mis_inst",  instruction_o, 32'h0000_0013);
        chk("mis_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd0);
        redirect_i     = 1'b0;
        bus.iwbm_ack_i = 1'b0;
        repeat (2) step();
        chk("halt_cyc",  {31'd0, bus.iwbm_cyc_o}, 32'd0);
        chk("halt_flag", {31'd0, e_inst_addr_misaligned_o}, 32'd1);
        chk("halt_pc_o", pc_o, 32'h8000_0102);

        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0010;
        step();
        chk("rd_valid", {31'd0, valid_o}, 32'd0);
        chk("rd_exc",   {30'd0, e_inst_addr_misaligned_o, e_inst_access_fault_o}, 32'd0);
        chk("rd_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("rd_addr",  bus.iwbm_addr_o, 32'h8000_0010);

        // bus error on 0x80000010
        redirect_i     = 1'b0;
        bus.iwbm_err_i = 1'b1;
        step();
        chk("err_valid", {31'd0, valid_o}, 32'd1);
        chk("err_fault", {31'd0, e_inst_access_fault_o}, 32'd1);
        chk("err_mis",   {31'd0, e_inst_addr_misaligned_o}, 32'd0);
        chk("err_pc_o",  pc_o, 32'h8000_0010);
        chk("err_inst",  instruction_o, 32'h0000_0013);
        chk("err_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd0);
        bus.iwbm_err_i = 1'b0;
        repeat (2) step();
        chk("errh_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd0);
        chk("errh_fault", {31'd0, e_inst_access_fault_o}, 32'd1);

        // redirect under stall: IF/ID flushed, cycle waits for stall release; pc wraps
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        stall_i       = 1'b1;
        step();
        chk("wr_cyc",   {31'd0, bus.iwbm_cyc_o}, 32'd0);
        chk("wr_valid", {31'd0, valid_o}, 32'd0);
        chk("wr_fault", {31'd0, e_inst_access_fault_o}, 32'd0);
        chk("wr_addr",  bus.iwbm_addr_o, 32'hFFFF_FFFC);
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        step();
        chk("wr2_cyc", {31'd0, bus.iwbm_cyc_o}, 32'd1);
        bus.iwbm_ack_i = 1'b1;
        bus.iwbm_dat_i = 32'h0000_0093;
        step();
        chk("wrap_pc_o",  pc_o, 32'hFFFF_FFFC);
        chk("wrap_addr",  bus.iwbm_addr_o, 32'h0000_0000);
        chk("wrap_valid", {31'd0, valid_o}, 32'd1);
        chk("wrap_inst",  instruction_o, 32'h0000_0093);
        bus.iwbm_ack_i = 1'b0;
        step();
        chk("pend_cyc", {31'd0, bus.iwbm_cyc_o}, 32'd1);

        // asynchronous reset in the middle of a pending cycle
        #2 rst_i = 1'b0;
        #1;
        chk("arst_cyc",   {30'd0, bus.iwbm_cyc_o, bus.iwbm_stb_o}, 32'd0);
        chk("arst_addr",  bus.iwbm_addr_o, 32'h8000_0000);
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        chk("rest_cyc",  {31'd0, bus.iwbm_cyc_o}, 32'd1);
        chk("rest_addr", bus.iwbm_addr_o, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
